deframer: RTL

DEFRAMER -- requirements
Module: deframer

---
 rtl/deframer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/deframer.sv
// Frame deframer: serialises 11-bit container words, hunts for the 44-bit marker and
// reassembles 16-bit payload words. Define DEFRAMER_ERRCNT_EN to add the errCount output.
module deframer #(
  parameter int unsigned FRAME_WORDS = 255,
  parameter int unsigned MISS_LIMIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] inWDAT,
  input  logic        inValid,
  output logic        inReady,
  output logic [15:0] outWord,
  output logic        outReady,
  output logic        locked,
  output logic [1:0]  markerIdx,
  output logic        frameErr
`ifdef DEFRAMER_ERRCNT_EN
  ,
  output logic [15:0] errCount
`endif
);

  localparam int unsigned FL = FRAME_WORDS * 11;
  localparam int unsigned CW = $clog2(FL);
  localparam int unsigned HW = 44;
  localparam logic [30:0] MARK_M = 31'b1111100110100100001010111011000;
  localparam logic [12:0] MARK_B = 13'b1111100110101;

  typedef enum logic {HUNT, LOCKED} stateType;

  stateType        state, nextState;
  logic [10:0]     serReg;
  logic [3:0]      serCnt;
  logic [HW-1:0]   history;
  logic [CW-1:0]   frameCnt;
  logic [2:0]      missCnt;
  logic [15:0]     asmReg;
  logic [3:0]      asmCnt;

  logic            bitValid;
  logic [HW-1:0]   newHist;
  logic            huntHit;
  logic [1:0]      huntIdx;
  logic            expHit;
  logic            windowEnd;
  logic            payloadBit;
  logic            lastMiss;
  logic [CW-1:0]   frameCntNext;
  logic            unusedMsb;

  assign unusedMsb = inWDAT[11];

  function automatic logic [HW-1:0] markerOf(input logic [1:0] idx);
    return {idx[0] ? ~MARK_M : MARK_M, idx[1] ? ~MARK_B : MARK_B};
  endfunction

  // Per-bit decode and next-state logic
  always_comb begin
    bitValid     = !inReady;
    newHist      = {history[HW-2:0], serReg[10]};
    huntHit      = 1'b0;
    huntIdx      = 2'd0;
    expHit       = (newHist == markerOf(markerIdx + 2'd1));
    windowEnd    = (frameCnt == CW'(HW - 1));
    payloadBit   = (frameCnt >= CW'(HW));
    lastMiss     = (missCnt == 3'(MISS_LIMIT - 1));
    frameCntNext = (frameCnt == CW'(FL - 1)) ? '0 : frameCnt + CW'(1);
    nextState    = state;
    for (int i = 0; i < 4; i++) begin
      if (!huntHit && newHist == markerOf(2'(i))) begin
        huntHit = 1'b1;
        huntIdx = 2'(i);
      end
    end
    if (bitValid) begin
      case (state)
        HUNT:    if (huntHit) nextState = LOCKED;
        LOCKED:  if (windowEnd && !expHit && lastMiss) nextState = HUNT;
        default: nextState = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= HUNT;
      locked <= 1'b0;
    end else begin
      state  <= nextState;
      locked <= (nextState == LOCKED);
    end
  end

  // Serialiser, history, frame counter and word assembler
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inReady   <= 1'b1;
      serReg    <= '0;
      serCnt    <= '0;
      history   <= '0;
      frameCnt  <= '0;
      missCnt   <= '0;
      asmReg    <= '0;
      asmCnt    <= '0;
      outWord   <= '0;
      outReady  <= 1'b0;
      markerIdx <= '0;
      frameErr  <= 1'b0;
`ifdef DEFRAMER_ERRCNT_EN
      errCount  <= '0;
`endif
    end else begin
      outReady <= 1'b0;
      frameErr <= 1'b0;
      if (inReady) begin
        if (inValid) begin
          serReg  <= inWDAT[10:0];
          serCnt  <= 4'd11;
          inReady <= 1'b0;
        end
      end else begin
        serReg  <= {serReg[9:0], 1'b0};
        serCnt  <= serCnt - 4'd1;
        history <= newHist;
        if (serCnt == 4'd1) inReady <= 1'b1;
        if (state == HUNT) begin
          if (huntHit) begin
            markerIdx <= huntIdx;
            frameCnt  <= CW'(HW);
            missCnt   <= '0;
            asmReg    <= '0;
            asmCnt    <= '0;
`ifdef DEFRAMER_ERRCNT_EN
            errCount  <= '0;
`endif
          end
        end else begin
          frameCnt <= frameCntNext;
          if (windowEnd) begin
            markerIdx <= markerIdx + 2'd1;
            if (expHit) begin
              missCnt <= '0;
            end else begin
              frameErr <= 1'b1;
`ifdef DEFRAMER_ERRCNT_EN
              if (errCount != 16'hFFFF) errCount <= errCount + 16'd1;
`endif
              // Losing lock drops any partially assembled word
              if (lastMiss) begin
                missCnt <= '0;
                asmReg  <= '0;
                asmCnt  <= '0;
              end else begin
                missCnt <= missCnt + 3'd1;
              end
            end
          end
          if (payloadBit) begin
            asmReg <= {asmReg[14:0], serReg[10]};
            asmCnt <= asmCnt + 4'd1;
            if (asmCnt == 4'd15) begin
              outWord  <= {asmReg[14:0], serReg[10]};
              outReady <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
